// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared data memory.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a contended acceptance.
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    owner_r;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    wen_r;
    logic                    rsp0_r;
    logic                    rsp1_r;
    logic [DATA_WIDTH-1:0]   rdata0_r;
    logic [DATA_WIDTH-1:0]   rdata1_r;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                    prio_r;
`endif

    logic                    gnt_s;
    logic                    accept_s;
    logic                    hs_s;
    logic                    sel_we_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic                    stall_s;

    // Pick the winning port among the currently valid requesters
    always_comb begin
        gnt_s = 1'b0;
        if (p0_valid && p1_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            gnt_s = 1'b0;
`else
            gnt_s = prio_r;
`endif
        end else if (p1_valid) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Acceptance window, handshake detect and request mux of the winner
    always_comb begin
        accept_s    = (state_r != BUSY);
        hs_s        = accept_s && (p0_valid || p1_valid);
        sel_we_s    = p0_we;
        sel_addr_s  = p0_addr;
        sel_wdata_s = p0_wdata;
        if (gnt_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // CPU stall: waiting for acceptance, or its own access still in progress
    always_comb begin
        stall_s = 1'b0;
        if (p0_valid && !p0_ready) begin
            stall_s = 1'b1;
        end else if (!owner_r && (state_r != IDLE)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign p0_ready     = accept_s && p0_valid && !gnt_s;
    assign p1_ready     = accept_s && p1_valid && gnt_s;
    assign cpu_stall    = stall_s;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;
    assign mem_wen      = wen_r;
    assign p0_rsp_valid = rsp0_r;
    assign p1_rsp_valid = rsp1_r;
    assign p0_rdata     = rdata0_r;
    assign p1_rdata     = rdata1_r;

    // Access sequencer: accept, count down the access, respond
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            owner_r  <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            wen_r    <= 1'b0;
            rsp0_r   <= 1'b0;
            rsp1_r   <= 1'b0;
            rdata0_r <= '0;
            rdata1_r <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            prio_r   <= 1'b0;
`endif
        end else begin
            rsp0_r <= 1'b0;
            rsp1_r <= 1'b0;
            wen_r  <= 1'b0;
            case (state_r)
                IDLE, RESP: begin
                    if (hs_s) begin
                        owner_r <= gnt_s;
                        we_r    <= sel_we_s;
                        addr_r  <= sel_addr_s;
                        wdata_r <= sel_wdata_s;
                        cnt_r   <= CNT_LOAD;
                        state_r <= BUSY;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        prio_r  <= ~gnt_s;
`endif
                        // A one-cycle access writes in the very first BUSY cycle
                        if (ACCESS_CYCLES == 1) begin
                            wen_r <= sel_we_s;
                        end else begin
                            wen_r <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r == 4'd0) begin
                        if (!we_r && !owner_r) begin
                            rdata0_r <= mem_rdata;
                        end else if (!we_r && owner_r) begin
                            rdata1_r <= mem_rdata;
                        end else begin
                            rdata0_r <= rdata0_r;
                        end
                        rsp0_r  <= ~owner_r;
                        rsp1_r  <= owner_r;
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                        if (cnt_r == 4'd1) begin
                            wen_r <= we_r;
                        end else begin
                            wen_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
